// File: rtl/ram_64x32_arb_if.sv
// ram_64x32_arb_if: requester A/B handshakes, shared read data and the RAM port of ram_64x32_arb.
interface ram_64x32_arb_if;
    logic        a_req;
    logic        a_we;
    logic [5:0]  a_addr;
    logic [31:0] a_wdata;
    logic        a_gnt;
    logic        a_rvalid;
    logic        b_req;
    logic        b_we;
    logic [5:0]  b_addr;
    logic [31:0] b_wdata;
    logic        b_gnt;
    logic        b_rvalid;
    logic [31:0] rdata;
    logic        busy;
    logic [31:0] ram_d;
    logic [5:0]  ram_waddr;
    logic [5:0]  ram_raddr;
    logic        ram_we;
    logic [31:0] ram_q;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_q,
        output a_gnt, a_rvalid, b_gnt, b_rvalid, rdata, busy, ram_d, ram_waddr, ram_raddr, ram_we
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_q,
        input  a_gnt, a_rvalid, b_gnt, b_rvalid, rdata, busy, ram_d, ram_waddr, ram_raddr, ram_we
    );
endinterface

// File: rtl/ram_64x32_arb.sv
// ram_64x32_arb: round-robin arbiter giving two requesters access to a 64x32 synchronous RAM.
// Define RAM_ARB_INIT_EN to include the post-reset sweep that writes INIT_VAL to every word.
module ram_64x32_arb #(
    parameter logic [31:0] INIT_VAL = 32'h0
) (
    input logic            c,
    input logic            r,
    ram_64x32_arb_if.slave bus
);
    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    logic last_q, last_d;
    logic a_rvalid_q, a_rvalid_d;
    logic b_rvalid_q, b_rvalid_d;
    logic a_gnt, b_gnt, busy;

`ifdef RAM_ARB_INIT_EN
    typedef enum logic {INIT, ARB} state_t;
    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;

    // Sweep one word per cycle; the counter parks at 63 and the FSM hands over to ARB
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        if (state_q == INIT) begin
            busy    = 1'b1;
            cnt_d   = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
            state_d = (cnt_q == 6'd63) ? ARB : INIT;
        end
    end

    // State and sweep counter; a reset restarts the sweep from address 0
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    assign busy = 1'b0;
`endif

    // Round-robin grant and RAM port steering; the sweep owns the write port while busy
    always_comb begin
        a_gnt         = !busy && bus.a_req && (!bus.b_req || last_q == GRANT_B);
        b_gnt         = !busy && bus.b_req && (!bus.a_req || last_q == GRANT_A);
        last_d        = a_gnt ? GRANT_A : b_gnt ? GRANT_B : last_q;
        a_rvalid_d    = a_gnt && !bus.a_we;
        b_rvalid_d    = b_gnt && !bus.b_we;
        bus.ram_we    = (a_gnt && bus.a_we) || (b_gnt && bus.b_we);
        bus.ram_waddr = a_gnt ? bus.a_addr : b_gnt ? bus.b_addr : 6'd0;
        bus.ram_raddr = a_gnt ? bus.a_addr : b_gnt ? bus.b_addr : 6'd0;
        bus.ram_d     = a_gnt ? bus.a_wdata : b_gnt ? bus.b_wdata : INIT_VAL;
`ifdef RAM_ARB_INIT_EN
        if (busy) begin
            bus.ram_we    = 1'b1;
            bus.ram_waddr = cnt_q;
        end
`endif
    end

    // Last-granted requester and one-cycle read-valid pulses aligned with ram_q
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            last_q     <= GRANT_B;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
        end
    end

    assign bus.a_gnt    = a_gnt;
    assign bus.b_gnt    = b_gnt;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.rdata    = bus.ram_q;
    assign bus.busy     = busy;
endmodule

// File: doc/ram_64x32_arb.md
RAM_64X32_ARB -- requirements
Module: ram_64x32_arb

Interface
REQ-001 SHALL have parameter INIT_VAL, default 32'h0, the word written to every location during the init sweep.
REQ-002 SHALL have port c  input  1  clock; all registers update on its rising edge.
REQ-003 SHALL have port r  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have ports a_req/b_req  input  1  requester A (host) / B (control loop) access request.
REQ-005 SHALL have ports a_we/b_we  input  1  1 = write, 0 = read; qualified by the matching req.
REQ-006 SHALL have ports a_addr/b_addr  input  6  word address.
REQ-007 SHALL have ports a_wdata/b_wdata  input  32  write data.
REQ-008 SHALL have ports a_gnt/b_gnt  output  1  combinational grant; the access executes in this cycle.
REQ-009 SHALL have ports a_rvalid/b_rvalid  output  1  registered; read data valid.
REQ-010 SHALL have port rdata  output  32  shared read data; equals ram_q.
REQ-011 SHALL have port busy  output  1  init sweep in progress.
REQ-012 SHALL have ports ram_d (output, 32), ram_waddr (output, 6), ram_raddr (output, 6) and ram_we (output, 1) driving the 64x32 synchronous RAM, and port ram_q (input, 32) receiving its output.

Function
REQ-013 SHALL grant at most one requester per cycle: a_gnt & b_gnt is never 1.
REQ-014 SHALL grant a lone requester immediately when not busy.
REQ-015 SHALL resolve conflicts round-robin: when both request, grant the requester not in register last; last <= granted requester on every grant.
REQ-016 SHALL keep each requester's req, we, addr and wdata stable until its gnt; a dropped req leaves no state.
REQ-017 SHALL drive ram_waddr, ram_raddr and ram_d from the granted requester, and drive ram_we = gnt & we.
REQ-018 SHALL assert the matching rvalid for exactly one cycle, one cycle after a read grant, with rdata = RAM contents at that address.
REQ-019 SHALL return the new data for a read granted the cycle after a write to the same address, with no hazard logic needed.
REQ-020 SHALL implement states INIT and ARB: INIT writes INIT_VAL to addresses 0..63 at one per cycle with a 6-bit counter, then moves to ARB after address 63 is written.
REQ-021 SHALL hold busy = 1 and both gnt = 0 throughout INIT; requests are held off, not dropped.
REQ-022 SHALL let the init counter reach 63 and then stop; the sweep does not wrap.
REQ-023 SHALL keep ram_we = 0 and address outputs at 0 when in ARB with no grant.

Reset
REQ-024 SHALL, on r = 1, immediately set last = B, set a_rvalid = b_rvalid = 0, clear the init counter to 0, and enter INIT, or ARB when the init feature is excluded.
REQ-025 SHALL, on reset asserted mid-sweep, restart the sweep at address 0 after release.
REQ-026 SHALL, on reset asserted with a read in flight, drop the read with no rvalid.
REQ-027 SHALL perform the first post-reset conflict grant to A.

Configuration
REQ-028 SHALL, with RAM_ARB_INIT_EN defined, include the INIT state, counter and busy behaviour as specified.
REQ-029 SHALL, with RAM_ARB_INIT_EN undefined, omit INIT and the counter, tie busy to 0, leave RAM contents undefined, and allow arbitration from the first cycle after reset.

Verification
REQ-030 SHALL verify: reset, then B reads addr 5 on the first ARB cycle -> busy high for 64 cycles, then b_rvalid with rdata = INIT_VAL (init enabled).
REQ-031 SHALL verify: A writes 32'hDEADBEEF to addr 10, then A reads addr 10 on the next cycle -> a_rvalid one cycle after the read grant, rdata = 32'hDEADBEEF.
REQ-032 SHALL verify: A and B request continuously after reset -> grants alternate A, B, A, B and never overlap.
REQ-033 SHALL verify: A writes addr 63 = 1 and B writes addr 0 = 2 in the same cycle -> both writes complete within 2 cycles and readback gives 1 and 2.
REQ-034 SHALL verify: r pulsed at init address 30 -> sweep restarts at 0, and busy falls 64 cycles after release.
REQ-035 SHALL verify: r asserted in the cycle after a B read grant -> b_rvalid stays 0.
